// File: rtl/apb_pkg.sv
// Shared APB bus widths, FSM state, response bundle and alignment check.
package apb_pkg;

  localparam int ADDR_WIDTH = 16;
  localparam int DATA_WIDTH = 32;
  localparam int TIMEOUT    = 16;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS
  } state;

  typedef struct packed {
    logic [DATA_WIDTH-1:0] rdata;
    logic                  err;
    logic                  timeout;
  } apb_rsp_t;

  // Transfers are whole data words, so the byte address must be word aligned.
  function automatic logic validAlign(input logic [ADDR_WIDTH-1:0] addr);
    return (addr & ADDR_WIDTH'(DATA_WIDTH/8 - 1)) == '0;
  endfunction

endpackage

// File: rtl/apb_requester_if.sv
// Host request/response channel plus APB4 signals of one requester.
interface apb_requester_if #(
    parameter int ADDR_WIDTH = apb_pkg::ADDR_WIDTH,
    parameter int DATA_WIDTH = apb_pkg::DATA_WIDTH,
    parameter int STRB_WIDTH = DATA_WIDTH/8
);
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_write;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [DATA_WIDTH-1:0] req_wdata;
    logic [STRB_WIDTH-1:0] req_strb;
    logic                  rsp_valid;
    logic [DATA_WIDTH-1:0] rsp_rdata;
    logic                  rsp_err;
    logic                  rsp_timeout;
    logic                  PSEL;
    logic                  PENABLE;
    logic                  PWRITE;
    logic [ADDR_WIDTH-1:0] PADDR;
    logic [DATA_WIDTH-1:0] PWDATA;
    logic [STRB_WIDTH-1:0] PSTRB;
    logic                  PREADY;
    logic [DATA_WIDTH-1:0] PRDATA;
    logic                  PSLVERR;

    modport master (
        input  req_valid, req_write, req_addr, req_wdata, req_strb,
        output req_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
        output PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB,
        input  PREADY, PRDATA, PSLVERR
    );

    modport slave (
        output req_valid, req_write, req_addr, req_wdata, req_strb,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
        input  PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB,
        output PREADY, PRDATA, PSLVERR
    );
endinterface

// File: rtl/apb_wait_timer.sv
// Counts consecutive ACCESS wait states; flags the cycle that exhausts the budget.
module apb_wait_timer #(
    parameter int TIMEOUT = apb_pkg::TIMEOUT
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clear_i,
    input  logic en_i,
    output logic expired_o
);
    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] LAST = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;

    logic [CW-1:0] cnt_q, cnt_d;

    // The TIMEOUT-th wait cycle expires instead of counting, so no wrap.
    assign expired_o = (TIMEOUT != 0) && en_i && (cnt_q == LAST);

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (en_i && !expired_o) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
endmodule

// File: rtl/apb_requester.sv
// APB4 requester: host command in, SETUP/ACCESS on the bus, one-cycle response out.
module apb_requester #(
    parameter int ADDR_WIDTH = apb_pkg::ADDR_WIDTH,
    parameter int DATA_WIDTH = apb_pkg::DATA_WIDTH,
    parameter int STRB_WIDTH = DATA_WIDTH/8,
    parameter int TIMEOUT    = apb_pkg::TIMEOUT
) (
    input logic           PCLK,
    input logic           PRESET,
    apb_requester_if.master bus
);
    import apb_pkg::*;

    localparam int PAW = apb_pkg::ADDR_WIDTH;
    localparam int PDW = apb_pkg::DATA_WIDTH;

    state                  st_q, st_d;
    logic                  psel_q, psel_d;
    logic                  pen_q, pen_d;
    logic                  pwrite_q, pwrite_d;
    logic [ADDR_WIDTH-1:0] paddr_q, paddr_d;
    logic [DATA_WIDTH-1:0] pwdata_q, pwdata_d;
    logic [STRB_WIDTH-1:0] pstrb_q, pstrb_d;
    logic                  rv_q, rv_d;
    apb_rsp_t              rsp_q, rsp_d;
    logic                  clr, en, expired;

    apb_wait_timer #(.TIMEOUT(TIMEOUT)) u_timer (
        .clk_i    (PCLK),
        .rst_i    (PRESET),
        .clear_i  (clr),
        .en_i     (en),
        .expired_o(expired)
    );

    always_comb begin
        st_d     = st_q;
        psel_d   = 1'b0;
        pen_d    = 1'b0;
        pwrite_d = pwrite_q;
        paddr_d  = paddr_q;
        pwdata_d = pwdata_q;
        pstrb_d  = pstrb_q;
        rv_d     = 1'b0;
        rsp_d    = '0;
        clr      = 1'b0;
        en       = 1'b0;
        unique case (st_q)
            IDLE: begin
                if (bus.req_valid) begin
                    if (validAlign(PAW'(bus.req_addr))) begin
                        st_d     = SETUP;
                        psel_d   = 1'b1;
                        clr      = 1'b1;
                        pwrite_d = bus.req_write;
                        paddr_d  = bus.req_addr;
                        pwdata_d = bus.req_wdata;
                        pstrb_d  = bus.req_write ? bus.req_strb : '0;
                    end else begin
                        rv_d      = 1'b1;
                        rsp_d.err = 1'b1;
                    end
                end
            end
            SETUP: begin
                st_d   = ACCESS;
                psel_d = 1'b1;
                pen_d  = 1'b1;
            end
            ACCESS: begin
                en = !bus.PREADY;
                // A completion in the last allowed cycle beats the timeout.
                if (bus.PREADY) begin
                    st_d      = IDLE;
                    rv_d      = 1'b1;
                    rsp_d.err = bus.PSLVERR;
                    if (!pwrite_q && !bus.PSLVERR) begin
                        rsp_d.rdata = PDW'(bus.PRDATA);
                    end
                end else if (expired) begin
                    st_d          = IDLE;
                    rv_d          = 1'b1;
                    rsp_d.err     = 1'b1;
                    rsp_d.timeout = 1'b1;
                end else begin
                    psel_d = 1'b1;
                    pen_d  = 1'b1;
                end
            end
            default: st_d = IDLE;
        endcase
    end

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            st_q     <= IDLE;
            psel_q   <= 1'b0;
            pen_q    <= 1'b0;
            pwrite_q <= 1'b0;
            paddr_q  <= '0;
            pwdata_q <= '0;
            pstrb_q  <= '0;
            rv_q     <= 1'b0;
            rsp_q    <= '0;
        end else begin
            st_q     <= st_d;
            psel_q   <= psel_d;
            pen_q    <= pen_d;
            pwrite_q <= pwrite_d;
            paddr_q  <= paddr_d;
            pwdata_q <= pwdata_d;
            pstrb_q  <= pstrb_d;
            rv_q     <= rv_d;
            rsp_q    <= rsp_d;
        end
    end

    assign bus.req_ready   = (st_q == IDLE);
    assign bus.PSEL        = psel_q;
    assign bus.PENABLE     = pen_q;
    assign bus.PWRITE      = pwrite_q;
    assign bus.PADDR       = paddr_q;
    assign bus.PWDATA      = pwdata_q;
    assign bus.PSTRB       = pstrb_q;
    assign bus.rsp_valid   = rv_q;
    assign bus.rsp_rdata   = DATA_WIDTH'(rsp_q.rdata);
    assign bus.rsp_err     = rsp_q.err;
    assign bus.rsp_timeout = rsp_q.timeout;
endmodule

// File: tb/tb_apb_requester.sv
// Directed and randomized transfers against a cycle-count model of the requester.
module tb_apb_requester;
    localparam int TO = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   tests = 0;
    int   fails = 0;

    logic [15:0] last_paddr = '0;
    logic [31:0] last_pwdata = '0;
    logic        last_pwrite = 1'b0;
    logic [3:0]  last_pstrb = '0;

    always #5 clk = ~clk;

    apb_requester_if #(.ADDR_WIDTH(16), .DATA_WIDTH(32), .STRB_WIDTH(4)) bus ();

    apb_requester #(
        .ADDR_WIDTH(16), .DATA_WIDTH(32), .STRB_WIDTH(4), .TIMEOUT(TO)
    ) dut (
        .PCLK  (clk),
        .PRESET(rst),
        .bus   (bus)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, ".ready"}, 64'(bus.req_ready), 64'd1);
        chk({tag, ".psel"}, 64'(bus.PSEL), 64'd0);
        chk({tag, ".pen"}, 64'(bus.PENABLE), 64'd0);
        chk({tag, ".pwrite"}, 64'(bus.PWRITE), 64'd0);
        chk({tag, ".paddr"}, 64'(bus.PADDR), 64'd0);
        chk({tag, ".pwdata"}, 64'(bus.PWDATA), 64'd0);
        chk({tag, ".pstrb"}, 64'(bus.PSTRB), 64'd0);
        chk({tag, ".rv"}, 64'(bus.rsp_valid), 64'd0);
        chk({tag, ".err"}, 64'(bus.rsp_err), 64'd0);
        chk({tag, ".tmo"}, 64'(bus.rsp_timeout), 64'd0);
        chk({tag, ".rdata"}, 64'(bus.rsp_rdata), 64'd0);
    endtask

    // Starts in an IDLE cycle (cycle 0) and returns in the response cycle,
    // so a following call accepts back-to-back in that response cycle.
    task automatic xfer(input string name, input logic wr,
                        input logic [15:0] addr, input logic [31:0] wdata,
                        input logic [3:0] strb, input int waits,
                        input logic [31:0] prdata, input logic slverr);
        logic mis, tmo, exp_err;
        logic [31:0] exp_rd;
        logic [3:0]  exp_strb;
        int last;
        mis      = (addr % 4) != 0;
        tmo      = !mis && (waits >= TO);
        last     = tmo ? 1 + TO : 2 + waits;
        exp_err  = mis || tmo || slverr;
        exp_rd   = (!wr && !exp_err) ? prdata : 32'd0;
        exp_strb = wr ? strb : 4'd0;

        chk({name, ".c0.ready"}, 64'(bus.req_ready), 64'd1);
        bus.req_valid = 1'b1;
        bus.req_write = wr;
        bus.req_addr  = addr;
        bus.req_wdata = wdata;
        bus.req_strb  = strb;
        bus.PREADY    = 1'($urandom_range(0, 1));
        tick();
        bus.req_valid = 1'b0;
        bus.req_write = 1'($urandom_range(0, 1));
        bus.req_addr  = 16'($urandom);
        bus.req_wdata = $urandom;
        bus.req_strb  = 4'($urandom);

        if (mis) begin
            bus.PREADY = 1'b0;
            chk({name, ".mis.psel"}, 64'(bus.PSEL), 64'd0);
            chk({name, ".mis.pen"}, 64'(bus.PENABLE), 64'd0);
            chk({name, ".mis.rv"}, 64'(bus.rsp_valid), 64'd1);
            chk({name, ".mis.err"}, 64'(bus.rsp_err), 64'd1);
            chk({name, ".mis.tmo"}, 64'(bus.rsp_timeout), 64'd0);
            chk({name, ".mis.rdata"}, 64'(bus.rsp_rdata), 64'd0);
            chk({name, ".mis.paddr"}, 64'(bus.PADDR), 64'(last_paddr));
            chk({name, ".mis.pstrb"}, 64'(bus.PSTRB), 64'(last_pstrb));
            chk({name, ".mis.pwdata"}, 64'(bus.PWDATA), 64'(last_pwdata));
            chk({name, ".mis.pwrite"}, 64'(bus.PWRITE), 64'(last_pwrite));
            return;
        end

        for (int c = 1; c <= last + 1; c++) begin
            if (c > 1) tick();
            if (c < 2) begin
                bus.PREADY  = 1'($urandom_range(0, 1));
                bus.PRDATA  = $urandom;
                bus.PSLVERR = 1'($urandom_range(0, 1));
            end else if (c == 2 + waits) begin
                bus.PREADY  = 1'b1;
                bus.PRDATA  = prdata;
                bus.PSLVERR = slverr;
            end else begin
                bus.PREADY  = 1'b0;
                bus.PRDATA  = $urandom;
                bus.PSLVERR = 1'($urandom_range(0, 1));
            end
            chk($sformatf("%s.c%0d.psel", name, c), 64'(bus.PSEL),
                64'(c <= last));
            chk($sformatf("%s.c%0d.pen", name, c), 64'(bus.PENABLE),
                64'(c >= 2 && c <= last));
            chk($sformatf("%s.c%0d.rv", name, c), 64'(bus.rsp_valid),
                64'(c == last + 1));
            chk($sformatf("%s.c%0d.ready", name, c), 64'(bus.req_ready),
                64'(c == last + 1));
            chk($sformatf("%s.c%0d.paddr", name, c), 64'(bus.PADDR),
                64'(addr));
            chk($sformatf("%s.c%0d.pwrite", name, c), 64'(bus.PWRITE),
                64'(wr));
            chk($sformatf("%s.c%0d.pwdata", name, c), 64'(bus.PWDATA),
                64'(wdata));
            chk($sformatf("%s.c%0d.pstrb", name, c), 64'(bus.PSTRB),
                64'(exp_strb));
        end
        bus.PREADY = 1'b0;
        chk({name, ".rsp.err"}, 64'(bus.rsp_err), 64'(exp_err));
        chk({name, ".rsp.tmo"}, 64'(bus.rsp_timeout), 64'(tmo));
        chk({name, ".rsp.rdata"}, 64'(bus.rsp_rdata), 64'(exp_rd));
        last_paddr  = addr;
        last_pwdata = wdata;
        last_pwrite = wr;
        last_pstrb  = exp_strb;
    endtask

    initial begin
        bus.req_valid = 1'b0;
        bus.req_write = 1'b0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
        bus.req_strb  = '0;
        bus.PREADY    = 1'b0;
        bus.PRDATA    = '0;
        bus.PSLVERR   = 1'b0;
        rst = 1'b1;
        tick();
        tick();
        chk_idle_outputs("reset");
        rst = 1'b0;
        tick();
        chk_idle_outputs("post_reset");

        xfer("wr0", 1'b1, 16'h0010, 32'hDEADBEEF, 4'hF, 0, 32'h0, 1'b0);
        tick();
        xfer("rd3", 1'b0, 16'h0004, 32'h0, 4'h5, 3, 32'h12345678, 1'b0);
        tick();
        xfer("mis", 1'b1, 16'h0006, 32'h11112222, 4'h3, 0, 32'h0, 1'b0);
        tick();
        xfer("tmo", 1'b0, 16'h0020, 32'h0, 4'h0, TO, 32'hCAFEF00D, 1'b0);
        tick();
        xfer("edge", 1'b0, 16'h0024, 32'h0, 4'h0, TO - 1, 32'hA5A55A5A, 1'b0);
        tick();
        xfer("slverr", 1'b1, 16'h0030, 32'h01020304, 4'h6, 1, 32'hFFFF, 1'b1);
        xfer("b2b1", 1'b1, 16'h0040, 32'h55AA55AA, 4'h9, 0, 32'h0, 1'b0);
        xfer("b2b2", 1'b0, 16'h0044, 32'h0, 4'hF, 2, 32'h87654321, 1'b0);
        xfer("b2b3", 1'b0, 16'h0049, 32'h0, 4'hF, 0, 32'h0, 1'b0);
        xfer("b2b4", 1'b1, 16'h004C, 32'h0BADCAFE, 4'hC, 0, 32'h0, 1'b0);
        tick();

        // Reset arriving mid-ACCESS drops the transfer without a response.
        chk("rstmid.c0.ready", 64'(bus.req_ready), 64'd1);
        bus.req_valid = 1'b1;
        bus.req_write = 1'b1;
        bus.req_addr  = 16'h0080;
        bus.req_wdata = 32'h13579BDF;
        bus.req_strb  = 4'hF;
        tick();
        bus.req_valid = 1'b0;
        bus.PREADY    = 1'b0;
        tick();
        chk("rstmid.c2.pen", 64'(bus.PENABLE), 64'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk_idle_outputs("rstmid.c3");
        tick();
        chk("rstmid.c4.rv", 64'(bus.rsp_valid), 64'd0);
        chk("rstmid.c4.psel", 64'(bus.PSEL), 64'd0);
        last_paddr  = '0;
        last_pwdata = '0;
        last_pwrite = 1'b0;
        last_pstrb  = '0;

        for (int i = 0; i < 40; i++) begin
            logic [15:0] a;
            a = 16'($urandom_range(0, 255) * 4);
            if ($urandom_range(0, 3) == 0) a = a | 16'($urandom_range(1, 3));
            xfer($sformatf("rnd%0d", i), 1'($urandom_range(0, 1)), a,
                 $urandom, 4'($urandom), int'($urandom_range(0, TO + 2)),
                 $urandom, ($urandom_range(0, 3) == 0));
            if ($urandom_range(0, 1) == 1) tick();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/apb_requester.md
# apb_requester

Bus-side APB4 requester that turns single-transfer commands from a local host into APB SETUP/ACCESS sequences and returns the completion response. It drives the completer peripherals sharing `apb_pkg` and uses the package's `state` enum, bus widths and `validAlign` check. It also owns alignment rejection and a wait-state timeout, so a hung completer cannot stall the host.

## Interface
- `ADDR_WIDTH`, default `apb_pkg::ADDR_WIDTH` (16): PADDR and request-address width.
- `DATA_WIDTH`, default `apb_pkg::DATA_WIDTH` (32): read and write data width.
- `STRB_WIDTH`, default `DATA_WIDTH/8`: byte-strobe width.
- `TIMEOUT`, default `apb_pkg::TIMEOUT` (16): maximum number of consecutive ACCESS cycles with PREADY=0. 0 disables the timeout.
- `PCLK` in 1: single clock; all logic is on its rising edge.
- `PRESET` in 1: synchronous, active-high reset.
- `req_valid` in 1: host request valid.
- `req_ready` out 1: high only in IDLE; a request is accepted when `req_valid && req_ready`.
- `req_write` in 1: 1 = write, 0 = read.
- `req_addr` in ADDR_WIDTH: byte address.
- `req_wdata` in DATA_WIDTH: write data.
- `req_strb` in STRB_WIDTH: write byte strobes.
- `rsp_valid` out 1: one-cycle completion pulse; the host cannot apply backpressure.
- `rsp_rdata` out DATA_WIDTH: read data. 0 for writes and errors.
- `rsp_err` out 1: PSLVERR, misaligned address, or timeout.
- `rsp_timeout` out 1: error cause was a timeout.
- `PSEL` out 1, `PENABLE` out 1, `PWRITE` out 1: APB control.
- `PADDR` out ADDR_WIDTH: APB address.
- `PWDATA` out DATA_WIDTH: APB write data.
- `PSTRB` out STRB_WIDTH: APB write strobes.
- `PREADY` in 1, `PRDATA` in DATA_WIDTH, `PSLVERR` in 1: completer response.

## Operation
- FSM states use `apb_pkg::state`: IDLE, SETUP, ACCESS.
- **IDLE**
  - `req_ready`=1, `PSEL`=0, `PENABLE`=0.
  - On accept with `validAlign(req_addr)` true: register `req_write`, `req_addr`, `req_wdata` and `req_strb` into the P* outputs, then go to SETUP.
  - For reads, PSTRB is forced to 0.
- **Misaligned accept:** no APB activity and the FSM stays in IDLE. The next cycle has `rsp_valid`=1, `rsp_err`=1, `rsp_timeout`=0, `rsp_rdata`=0.
- **SETUP:** `PSEL`=1, `PENABLE`=0. Unconditionally go to ACCESS.
- **ACCESS:** `PSEL`=1, `PENABLE`=1.
  - PREADY=1: capture PRDATA (reads only; writes capture 0) and PSLVERR, then go to IDLE.
  - PREADY=0: increment the wait counter.
  - If the counter reaches TIMEOUT (TIMEOUT≠0), abandon the transfer and go to IDLE with `rsp_err`=1 and `rsp_timeout`=1.
- **Wait counter:** width `$clog2(TIMEOUT+1)`. Cleared on entry to SETUP. It never wraps because it is checked before incrementing.
- **P* outputs between transfers:** PADDR, PWDATA, PWRITE and PSTRB hold their last values while idle. PSEL and PENABLE are only ever high in SETUP and ACCESS.
- **Request inputs:** ignored outside IDLE; `req_ready`=0 there.
- **Same-cycle events:** a `rsp_valid` cycle may coincide with a new accept, since IDLE is entered in that cycle.
- **Reset:** PRESET in any state, including mid-transfer, means the next cycle is IDLE with all outputs 0. No response is issued for the aborted transfer.

## Timing
- **Reset values:** every output is 0 except `req_ready`, which is 1.
- **Normal transfer, accept in cycle 0:**
  - cycle 1: SETUP.
  - cycle 2: first ACCESS.
  - PREADY=1 in cycle 2+N: `rsp_valid` in cycle 3+N.
  - Minimum accept-to-response latency is 3 cycles; back-to-back accept period is 3+N.
- **Misaligned request:** response 1 cycle after accept.
- **Timeout:** the last ACCESS cycle is cycle 1+TIMEOUT, and `rsp_valid` follows in cycle 2+TIMEOUT. PREADY=1 in that last cycle wins over the timeout.
- **APB stability:** all APB outputs are registered. PADDR, PWRITE, PWDATA and PSTRB are stable from SETUP through the end of ACCESS.

## Structure
- **Additions to `apb_pkg`:**
  - `TIMEOUT` default constant.
  - Packed struct `apb_rsp_t` with fields {rdata, err, timeout}.
- **Reused from `apb_pkg`:** the `state` enum and `validAlign` are used directly.
- **Sub-module:** `apb_wait_timer`, holding the wait counter.
  - Inputs: clear, enable.
  - Output: expired.
  - Parameter: TIMEOUT.

## Test plan
- **Write, zero wait:** write addr 0x0010, data 0xDEADBEEF, strb 0xF, PREADY tied 1.
  - PSEL in cycle 1; PENABLE only in cycle 2; PSTRB=0xF.
  - `rsp_valid` in cycle 3 with `rsp_err`=0.
- **Read with wait states:** read addr 0x0004, PREADY=0 for 3 ACCESS cycles, PRDATA=0x12345678.
  - `rsp_valid` in cycle 6 with `rsp_rdata`=0x12345678.
  - PSTRB=0 throughout.
- **Misaligned:** request at addr 0x0006.
  - PSEL never rises.
  - Next cycle: `rsp_err`=1, `rsp_timeout`=0.
- **Timeout:** TIMEOUT=4, PREADY held 0.
  - PENABLE high for exactly cycles 2–5.
  - `rsp_valid` in cycle 6 with `rsp_err`=1 and `rsp_timeout`=1.
  - PREADY=1 in cycle 5 instead gives a normal completion.
- **PSLVERR:** write completes with PSLVERR=1.
  - `rsp_err`=1, `rsp_timeout`=0, `rsp_rdata`=0.
- **Reset mid-ACCESS and back-to-back:**
  - PRESET in cycle 2: all outputs 0 in cycle 3, no `rsp_valid`.
  - Two back-to-back requests: second accepted in the first request's response cycle.
